// File: rtl/sdram_arbiter_if.sv
// Bundles the download writer, the ROM read ports and the sdram controller request bus.
// master = arbiter side, slave = requesters plus controller.
interface sdram_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
);
    logic                            dl_req;
    logic [ADDR_WIDTH-1:0]           dl_addr;
    logic [DATA_WIDTH-1:0]           dl_data;
    logic                            dl_ack;
    logic [NUM_PORTS-1:0]            port_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORTS-1:0]            port_ack;
    logic [NUM_PORTS-1:0]            port_valid;
    logic [DATA_WIDTH-1:0]           port_q;
    logic [ADDR_WIDTH-1:0]           sdram_addr;
    logic [DATA_WIDTH-1:0]           sdram_data;
    logic                            sdram_we;
    logic                            sdram_req;
    logic                            sdram_ack;
    logic                            sdram_valid;
    logic [DATA_WIDTH-1:0]           sdram_q;
    logic                            timeout;

    modport master (
        input  dl_req, dl_addr, dl_data, port_req, port_addr, sdram_ack, sdram_valid, sdram_q,
        output dl_ack, port_ack, port_valid, port_q, sdram_addr, sdram_data, sdram_we, sdram_req,
               timeout
    );
    modport slave (
        output dl_req, dl_addr, dl_data, port_req, port_addr, sdram_ack, sdram_valid, sdram_q,
        input  dl_ack, port_ack, port_valid, port_q, sdram_addr, sdram_data, sdram_we, sdram_req,
               timeout
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-transaction sdram arbiter: download writes win, reads are served round-robin.
// Optional watchdog abort enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    sdram_arbiter_if.master bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_VALID, DONE} state_t;

    state_t                state, state_d;
    logic [PW-1:0]         rr, rr_d, grant, grant_d, pick;
    logic                  grant_wr, grant_wr_d, found;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d, q_d;
    logic                  we_d, req_d, dl_ack_d, timeout_d;
    logic [NUM_PORTS-1:0]  ack_d, valid_d;
    int                    idx_i;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_d;
    wire timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // First requesting port at or above the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        idx_i = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_i = int'(rr) + k;
            if (idx_i >= NUM_PORTS) idx_i = idx_i - NUM_PORTS;
            if (!found && bus.port_req[idx_i[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx_i[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state;
        rr_d       = rr;
        grant_d    = grant;
        grant_wr_d = grant_wr;
        addr_d     = bus.sdram_addr;
        data_d     = bus.sdram_data;
        we_d       = bus.sdram_we;
        req_d      = bus.sdram_req;
        q_d        = bus.port_q;
        dl_ack_d   = 1'b0;
        ack_d      = '0;
        valid_d    = '0;
        timeout_d  = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d      = cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.dl_req) begin
                    grant_wr_d = 1'b1;
                    addr_d     = bus.dl_addr;
                    data_d     = bus.dl_data;
                    we_d       = 1'b1;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end else if (found) begin
                    grant_wr_d = 1'b0;
                    grant_d    = pick;
                    addr_d     = bus.port_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d     = '0;
                    we_d       = 1'b0;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    req_d = 1'b0;
                    if (grant_wr) begin
                        dl_ack_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        ack_d[grant] = 1'b1;
                        state_d      = WAIT_VALID;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    if (grant_wr) dl_ack_d = 1'b1;
                    else begin
                        valid_d[grant] = 1'b1;
                        q_d            = '0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            WAIT_VALID: begin
                if (bus.sdram_valid) begin
                    q_d            = bus.sdram_q;
                    valid_d[grant] = 1'b1;
                    state_d        = DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    timeout_d      = 1'b1;
                    valid_d[grant] = 1'b1;
                    q_d            = '0;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            DONE: begin
                // Writes leave the pointer alone so reads keep their turn order.
                if (!grant_wr) rr_d = (grant == LAST_PORT) ? '0 : grant + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr             <= '0;
            grant          <= '0;
            grant_wr       <= 1'b0;
            bus.sdram_addr <= '0;
            bus.sdram_data <= '0;
            bus.sdram_we   <= 1'b0;
            bus.sdram_req  <= 1'b0;
            bus.port_q     <= '0;
            bus.dl_ack     <= 1'b0;
            bus.port_ack   <= '0;
            bus.port_valid <= '0;
            bus.timeout    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt            <= '0;
`endif
        end else begin
            state          <= state_d;
            rr             <= rr_d;
            grant          <= grant_d;
            grant_wr       <= grant_wr_d;
            bus.sdram_addr <= addr_d;
            bus.sdram_data <= data_d;
            bus.sdram_we   <= we_d;
            bus.sdram_req  <= req_d;
            bus.port_q     <= q_d;
            bus.dl_ack     <= dl_ack_d;
            bus.port_ack   <= ack_d;
            bus.port_valid <= valid_d;
            bus.timeout    <= timeout_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt            <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: the bench plays both the requesters and the sdram controller.
module tb_sdram_arbiter;
    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] outs_or();
        return {bus.dl_ack, bus.port_ack, bus.port_valid, bus.sdram_we, bus.sdram_req, bus.timeout}
               | 32'(bus.sdram_addr) | bus.sdram_data | bus.port_q;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Controller model: waits for a request, acks after ack_dly cycles, returns read data.
    task automatic serve(input int ack_dly, input int val_dly, input bit drop,
                         output int g, output bit ok, output bit stable, output bit we,
                         output logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [DW-1:0] q, output logic [NP-1:0] v);
        g = -2; ok = 1'b0; stable = 1'b1; we = 1'b0; a = '0; d = '0; q = '0; v = '0;
        for (int i = 0; i < 100 && bus.sdram_req !== 1'b1; i++) @(negedge clk);
        if (bus.sdram_req !== 1'b1) return;
        a  = bus.sdram_addr;
        d  = bus.sdram_data;
        we = bus.sdram_we;
        repeat (ack_dly) begin
            @(negedge clk);
            if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== a || bus.sdram_data !== d ||
                bus.sdram_we !== we) stable = 1'b0;
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        if (bus.dl_ack === 1'b1) g = -1;
        for (int i = 0; i < NP; i++) if (bus.port_ack[i] === 1'b1) g = i;
        if (drop) begin
            bus.port_req = bus.port_req & ~bus.port_ack;
            if (bus.dl_ack === 1'b1) bus.dl_req = 1'b0;
        end
        if (!we) begin
            repeat (val_dly) @(negedge clk);
            bus.sdram_valid = 1'b1;
            bus.sdram_q     = 32'hA500_0000 | 32'(a);
            @(negedge clk);
            bus.sdram_valid = 1'b0;
            q = bus.port_q;
            v = bus.port_valid;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (outs_or() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs_or());
        end
    endtask

    task automatic test_single_read();
        int acks = 0;
        bus.port_addr[2*AW +: AW] = 23'h000100;
        bus.port_req = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 23'h000100 || bus.sdram_we !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: req=%b addr=%h we=%b expected 1/000100/0",
                     bus.sdram_req, bus.sdram_addr, bus.sdram_we);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 23'h000100) begin
            errors++;
            $display("FAIL read_hold: req=%b addr=%h expected 1/000100", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        checks++;
        if (bus.port_ack !== 4'b0100 || bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: port_ack=%b req=%b expected 0100/0", bus.port_ack, bus.sdram_req);
        end
        if (bus.port_ack !== 4'b0000) acks++;
        bus.port_req = 4'b0000;
        repeat (4) begin
            @(negedge clk);
            if (bus.port_ack !== 4'b0000) acks++;
        end
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'hDEADBEEF;
        @(negedge clk);
        bus.sdram_valid = 1'b0;
        checks++;
        if (bus.port_valid !== 4'b0100 || bus.port_q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_valid: valid=%b q=%h expected 0100/deadbeef", bus.port_valid, bus.port_q);
        end
        @(negedge clk);
        checks++;
        if (bus.port_valid !== 4'b0000 || bus.port_q !== 32'hDEADBEEF || acks != 1) begin
            errors++;
            $display("FAIL read_once: valid=%b q=%h acks=%0d expected 0000/deadbeef/1",
                     bus.port_valid, bus.port_q, acks);
        end
    endtask

    task automatic test_priority();
        int               exp_g [5] = '{-1, 0, 1, 2, 3};
        int               g;
        bit               ok, st, we;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d, q;
        logic [NP-1:0]    v;
        pulse_reset();
        for (int i = 0; i < NP; i++) bus.port_addr[i*AW +: AW] = 23'(16 + i);
        bus.dl_addr  = 23'h55;
        bus.dl_data  = 32'hCAFE0001;
        bus.dl_req   = 1'b1;
        bus.port_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1, 2, 1'b1, g, ok, st, we, a, d, q, v);
            checks++;
            if (!ok || !st || g != exp_g[i]) begin
                errors++;
                $display("FAIL prio[%0d]: ok=%b stable=%b grant=%0d expected grant %0d", i, ok, st, g, exp_g[i]);
            end
            checks++;
            if (i == 0) begin
                if (we !== 1'b1 || a !== 23'h55 || d !== 32'hCAFE0001) begin
                    errors++;
                    $display("FAIL prio_write: we=%b addr=%h data=%h expected 1/55/cafe0001", we, a, d);
                end
            end else if (q !== (32'hA500_0000 | 32'(16 + i - 1)) || v !== 4'(1 << (i - 1))) begin
                errors++;
                $display("FAIL prio_read[%0d]: q=%h valid=%b expected %h/%b", i, q, v,
                         32'hA500_0000 | 32'(16 + i - 1), 4'(1 << (i - 1)));
            end
        end
    endtask

    task automatic test_round_robin();
        int               exp_g [4] = '{0, 3, 0, 3};
        int               g;
        bit               ok, st, we;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d, q;
        logic [NP-1:0]    v;
        bus.port_req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1, 1'b0, g, ok, st, we, a, d, q, v);
            checks++;
            if (!ok || g != exp_g[i]) begin
                errors++;
                $display("FAIL rr[%0d]: ok=%b grant=%0d expected %0d", i, ok, g, exp_g[i]);
            end
        end
        bus.port_req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL rr_release: sdram_req=%b expected 0", bus.sdram_req);
        end
    endtask

    task automatic test_download();
        int               n_ack = 0;
        int               g;
        bit               ok, st, we;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d, q;
        logic [NP-1:0]    v;
        for (int i = 0; i < 8; i++) begin
            bus.dl_addr = 23'(i);
            bus.dl_data = 32'(i);
            bus.dl_req  = 1'b1;
            serve(i % 3, 0, 1'b1, g, ok, st, we, a, d, q, v);
            if (g == -1) n_ack++;
            checks++;
            if (!ok || !st || we !== 1'b1 || a !== 23'(i) || d !== 32'(i)) begin
                errors++;
                $display("FAIL dl[%0d]: ok=%b stable=%b we=%b addr=%h data=%h expected 1/1/1/%h/%h",
                         i, ok, st, we, a, d, 23'(i), 32'(i));
            end
        end
        checks++;
        if (n_ack != 8) begin
            errors++;
            $display("FAIL dl_ack_count: got %0d expected 8", n_ack);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen = 1'b0;
        bus.port_addr[0 +: AW] = 23'h200;
        bus.port_req = 4'b0001;
        for (int i = 0; i < 50 && bus.sdram_req !== 1'b1; i++) @(negedge clk);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        checks++;
        if (bus.port_ack !== 4'b0001) begin
            errors++;
            $display("FAIL to_ack: port_ack=%b expected 0001", bus.port_ack);
        end
        bus.port_req = 4'b0000;
`ifdef SDRAM_ARB_TIMEOUT_EN
        while (bus.timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16 || bus.port_valid !== 4'b0001 || bus.port_q !== '0) begin
            errors++;
            $display("FAIL to_fire: cycles=%0d valid=%b q=%h expected 16/0001/0", n, bus.port_valid, bus.port_q);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: timeout=%b expected 0", bus.timeout);
        end
`else
        repeat (40) begin
            @(negedge clk);
            n++;
            if (bus.timeout !== 1'b0 || bus.port_valid !== 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL to_disabled: early timeout/valid within %0d cycles", n);
        end
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'h0BADF00D;
        @(negedge clk);
        bus.sdram_valid = 1'b0;
        checks++;
        if (bus.port_valid !== 4'b0001 || bus.port_q !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL to_late_valid: valid=%b q=%h expected 0001/0badf00d", bus.port_valid, bus.port_q);
        end
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bus.port_addr[1*AW +: AW] = 23'h77;
        bus.port_req = 4'b0010;
        for (int i = 0; i < 50 && bus.sdram_req !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL rm_req: sdram_req=%b expected 1", bus.sdram_req);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        bus.port_req  = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_or() !== '0) begin
            errors++;
            $display("FAIL rm_reset: outputs %h expected 0", outs_or());
        end
        reset = 1'b0;
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'h12345678;
        @(negedge clk);
        bus.sdram_valid = 1'b0;
        repeat (3) begin
            if (outs_or() !== '0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rm_stray_valid: outputs became nonzero after stray sdram_valid, now %h", outs_or());
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.dl_req      = 1'b0;
        bus.dl_addr     = '0;
        bus.dl_data     = '0;
        bus.port_req    = '0;
        bus.port_addr   = '0;
        bus.sdram_ack   = 1'b0;
        bus.sdram_valid = 1'b0;
        bus.sdram_q     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_single_read();
        test_priority();
        test_round_robin();
        test_download();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
